// File: rtl/rot_pkg.sv
// Shared types and constants for the rotate/shift controller.
package rot_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ROTATE,
        DONE
    } state_t;

    localparam int ROT_WIDTH = 8;
    localparam int ROT_AMT_W = 3;

    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT  = 1'b1;

endpackage

// File: rtl/rot_shift_ctrl_if.sv
// Job request / result handshake bundle for rot_shift_ctrl.
interface rot_shift_ctrl_if #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 3
) ();

    logic             IN_VALID;
    logic             IN_READY;
    logic [WIDTH-1:0] Din;
    logic [AMT_W-1:0] AMT;
    logic             DIR;
    logic             OUT_VALID;
    logic             OUT_READY;
    logic [WIDTH-1:0] Dout;
    logic             BUSY;

    modport master (
        output IN_VALID, Din, AMT, DIR, OUT_READY,
        input  IN_READY, OUT_VALID, Dout, BUSY
    );

    modport slave (
        input  IN_VALID, Din, AMT, DIR, OUT_READY,
        output IN_READY, OUT_VALID, Dout, BUSY
    );

endinterface

// File: rtl/rot_reg.sv
// Loadable one-bit rotate register; left rotation only with ROT_LEFT_EN.
module rot_reg
    import rot_pkg::*;
#(
    parameter int WIDTH = ROT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             shift_en,
    input  logic             dir,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_nxt;

`ifdef ROT_LEFT_EN
    assign r_nxt = (dir == DIR_LEFT) ?
                   {q[WIDTH-2:0], q[WIDTH-1]} :
                   {q[0], q[WIDTH-1:1]};
`else
    logic unused_dir;
    assign unused_dir = dir;
    assign r_nxt = {q[0], q[WIDTH-1:1]};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end else if (shift_en) begin
            q <= r_nxt;
        end
    end

endmodule

// File: rtl/rot_shift_ctrl.sv
// Rotate controller: FSM, down-counter and handshake around rot_reg.
// Optional macro ROT_LEFT_EN enables DIR-selected left rotation.
module rot_shift_ctrl
    import rot_pkg::*;
#(
    parameter int WIDTH = ROT_WIDTH,
    parameter int AMT_W = ROT_AMT_W
) (
    input logic         CLK,
    input logic         RST_N,
    rot_shift_ctrl_if.slave bus
);

    state_t           state_q;
    state_t           state_d;
    logic [AMT_W-1:0] cnt_q;
    logic             load;
    logic             shift_en;
    logic             dir_q;
    logic [WIDTH-1:0] r_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        load     = 1'b0;
        shift_en = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.IN_VALID) begin
                    load    = 1'b1;
                    state_d = (bus.AMT == '0) ? DONE : ROTATE;
                end
            end
            ROTATE: begin
                shift_en = 1'b1;
                if (cnt_q == AMT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.OUT_READY) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Decrement only while rotating so the counter can never wrap.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= bus.AMT;
        end else if (shift_en) begin
            cnt_q <= cnt_q - AMT_W'(1);
        end
    end

`ifdef ROT_LEFT_EN
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            dir_q <= DIR_RIGHT;
        end else if (load) begin
            dir_q <= bus.DIR;
        end
    end
`else
    logic unused_dir;
    assign unused_dir = bus.DIR;
    assign dir_q      = DIR_RIGHT;
`endif

    rot_reg #(
        .WIDTH (WIDTH)
    ) u_reg (
        .clk      (CLK),
        .rst_n    (RST_N),
        .load     (load),
        .shift_en (shift_en),
        .dir      (dir_q),
        .d        (bus.Din),
        .q        (r_q)
    );

    assign bus.IN_READY  = (state_q == IDLE);
    assign bus.OUT_VALID = (state_q == DONE);
    assign bus.BUSY      = (state_q != IDLE);
    assign bus.Dout      = r_q;

endmodule

// File: tb/tb_rot_shift_ctrl.sv
// Scoreboard bench for rot_shift_ctrl (right rotate; left with ROT_LEFT_EN).
module tb_rot_shift_ctrl;

    logic CLK;
    logic RST_N;

    int ncmp;
    int nfail;

    logic [7:0] exp_q[$];
    int         lat_q[$];

    rot_shift_ctrl_if #(.WIDTH(8), .AMT_W(3)) bus ();

    rot_shift_ctrl #(
        .WIDTH (8),
        .AMT_W (3)
    ) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [7:0] model(input logic [7:0] d,
                                         input int a,
                                         input logic dr);
        logic [7:0] r;
        r = d;
        for (int i = 0; i < a; i++) begin
`ifdef ROT_LEFT_EN
            if (dr) r = {r[6:0], r[7]};
            else    r = {r[0], r[7:1]};
`else
            r = {r[0], r[7:1]};
`endif
        end
        return r;
    endfunction

    task automatic start_job(input logic [7:0] d, input logic [2:0] a,
                             input logic dr, input logic [7:0] e);
        int w;
        w = 0;
        while (bus.IN_READY !== 1'b1 && w < 50) begin
            @(posedge CLK); #1;
            w++;
        end
        if (bus.IN_READY !== 1'b1) begin
            ncmp++; nfail++;
            $display("FAIL accept_timeout: IN_READY=%b required 1", bus.IN_READY);
        end
        bus.IN_VALID = 1'b1;
        bus.Din      = d;
        bus.AMT      = a;
        bus.DIR      = dr;
        exp_q.push_back(e);
        lat_q.push_back(int'(a));
        @(posedge CLK); #1;
        bus.IN_VALID = 1'b0;
        bus.Din      = 8'($urandom);
        bus.AMT      = 3'($urandom);
        bus.DIR      = 1'($urandom);
    endtask

    task automatic finish_job(input int hold, input logic early_rdy);
        int         cyc;
        logic [7:0] e;
        int         l;
        cyc = 0;
        while (bus.OUT_VALID !== 1'b1 && cyc < 40) begin
            ncmp++;
            if (bus.BUSY !== 1'b1 || bus.IN_READY !== 1'b0) begin
                nfail++;
                $display("FAIL rotate_flags: BUSY=%b IN_READY=%b required 1/0",
                         bus.BUSY, bus.IN_READY);
            end
            bus.OUT_READY = early_rdy;
            @(posedge CLK); #1;
            cyc++;
        end
        bus.OUT_READY = 1'b0;
        if (exp_q.size() == 0) begin
            ncmp++; nfail++;
            $display("FAIL scoreboard_empty: size=0 required >0");
            return;
        end
        e = exp_q.pop_front();
        l = lat_q.pop_front();
        ncmp++;
        if (cyc !== l) begin
            nfail++;
            $display("FAIL latency: got %0d required %0d", cyc, l);
        end
        ncmp++;
        if (bus.Dout !== e) begin
            nfail++;
            $display("FAIL dout: got %h required %h", bus.Dout, e);
        end
        for (int i = 0; i < hold; i++) begin
            bus.IN_VALID = 1'($urandom);
            bus.Din      = 8'($urandom);
            @(posedge CLK); #1;
            ncmp++;
            if (bus.Dout !== e || bus.IN_READY !== 1'b0 ||
                bus.OUT_VALID !== 1'b1) begin
                nfail++;
                $display("FAIL hold: Dout=%h IN_READY=%b OUT_VALID=%b required %h/0/1",
                         bus.Dout, bus.IN_READY, bus.OUT_VALID, e);
            end
        end
        bus.IN_VALID  = 1'b0;
        bus.OUT_READY = 1'b1;
        @(posedge CLK); #1;
        bus.OUT_READY = 1'b0;
        ncmp++;
        if (bus.OUT_VALID !== 1'b0 || bus.IN_READY !== 1'b1 ||
            bus.BUSY !== 1'b0) begin
            nfail++;
            $display("FAIL release: OUT_VALID=%b IN_READY=%b BUSY=%b required 0/1/0",
                     bus.OUT_VALID, bus.IN_READY, bus.BUSY);
        end
    endtask

    task automatic test_reset();
        RST_N         = 1'b0;
        bus.IN_VALID  = 1'b1;
        bus.Din       = 8'h5A;
        bus.AMT       = 3'd2;
        bus.DIR       = 1'b0;
        bus.OUT_READY = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        ncmp++;
        if (bus.Dout !== 8'h00 || bus.OUT_VALID !== 1'b0 ||
            bus.BUSY !== 1'b0 || bus.IN_READY !== 1'b1) begin
            nfail++;
            $display("FAIL reset_state: Dout=%h OV=%b BUSY=%b IR=%b required 00/0/0/1",
                     bus.Dout, bus.OUT_VALID, bus.BUSY, bus.IN_READY);
        end
        bus.IN_VALID = 1'b0;
        @(negedge CLK);
        RST_N = 1'b1;
        @(posedge CLK); #1;
        ncmp++;
        if (bus.BUSY !== 1'b0 || bus.Dout !== 8'h00) begin
            nfail++;
            $display("FAIL post_reset_idle: BUSY=%b Dout=%h required 0/00",
                     bus.BUSY, bus.Dout);
        end
    endtask

    task automatic test_rotate_one();
        start_job(8'hA5, 3'd1, 1'b0, 8'hD2);
        finish_job(0, 1'b0);
    endtask

    task automatic test_amt_zero();
        start_job(8'hA5, 3'd0, 1'b0, 8'hA5);
        finish_job(0, 1'b0);
    endtask

    task automatic test_amt_max();
        start_job(8'h01, 3'd7, 1'b0, 8'h02);
        finish_job(0, 1'b1);
    endtask

    task automatic test_dir();
`ifdef ROT_LEFT_EN
        start_job(8'h81, 3'd1, 1'b1, 8'h03);
`else
        start_job(8'h81, 3'd1, 1'b1, 8'hC0);
`endif
        finish_job(0, 1'b0);
    endtask

    task automatic test_hold();
        start_job(8'h3C, 3'd3, 1'b0, 8'h87);
        finish_job(5, 1'b0);
    endtask

    task automatic test_reset_mid();
        bus.IN_VALID = 1'b1;
        bus.Din      = 8'hFF;
        bus.AMT      = 3'd5;
        bus.DIR      = 1'b0;
        @(posedge CLK); #1;
        bus.IN_VALID = 1'b0;
        repeat (2) @(posedge CLK);
        #2;
        RST_N = 1'b0;
        #1;
        ncmp++;
        if (bus.Dout !== 8'h00 || bus.OUT_VALID !== 1'b0 ||
            bus.BUSY !== 1'b0) begin
            nfail++;
            $display("FAIL async_reset: Dout=%h OV=%b BUSY=%b required 00/0/0",
                     bus.Dout, bus.OUT_VALID, bus.BUSY);
        end
        @(negedge CLK);
        RST_N = 1'b1;
        @(posedge CLK); #1;
        start_job(8'h96, 3'd2, 1'b0, 8'hA5);
        finish_job(0, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [7:0] d;
        logic [2:0] a;
        logic       dr;
        for (int i = 0; i < 12; i++) begin
            d  = 8'($urandom);
            a  = 3'($urandom);
            dr = 1'($urandom);
            start_job(d, a, dr, model(d, int'(a), dr));
            finish_job(i % 3, 1'($urandom));
        end
    endtask

    initial begin
        ncmp  = 0;
        nfail = 0;
        test_reset();
        test_rotate_one();
        test_amt_zero();
        test_amt_max();
        test_dir();
        test_hold();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
